music_mode_ctrl: RTL

- Front-end controller that sits directly upstream of the buzzer tone generator.
- Turns the board's seven note switches, a 2-bit octave selector and two pushbuttons (song, stop) into the 5-bit mode code that the tone generator consumes.
- Mode code map: 0 = silence; 1-7 = low do..si; 8-14 = mid do..si; 15-16 = high do/re; 17 = MerryChristmas; 18 = HappyBirthday; 19 = JiangNan.
- The tone generator restarts on every mode change, so this block must present a glitch-free, registered, stable mode.

---
 rtl/music_mode_ctrl_if.sv | 45 ++++
 rtl/music_mode_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/music_mode_ctrl_if.sv
// ----------------------------------------------------------------------------
// music_mode_ctrl_if
//
// Purpose:
//   Groups the board-facing controls and the tone-generator-facing mode code
//   of the music mode controller into one bundle.
//
// Signals:
//   note_sw    [6:0]  note switches, bit0 = do .. bit6 = si (asynchronous)
//   octave_sel [1:0]  0 = low, 1 = mid, 2 = high, 3 = mid
//   btn_song          raw song pushbutton, active-high, bouncy
//   btn_stop          raw stop pushbutton, active-high, bouncy
//   mode       [4:0]  registered mode code for the tone generator
//   playing           high while a note or a song is selected
//
// Modports:
//   master  drives the controls and observes the mode (board / testbench)
//   slave   consumes the controls and produces the mode (the controller)
// ----------------------------------------------------------------------------
interface music_mode_ctrl_if;
    logic [6:0] note_sw;
    logic [1:0] octave_sel;
    logic       btn_song;
    logic       btn_stop;
    logic [4:0] mode;
    logic       playing;

    modport master (
        output note_sw,
        output octave_sel,
        output btn_song,
        output btn_stop,
        input  mode,
        input  playing
    );

    modport slave (
        input  note_sw,
        input  octave_sel,
        input  btn_song,
        input  btn_stop,
        output mode,
        output playing
    );
endinterface

// File: rtl/music_mode_ctrl.sv
// ----------------------------------------------------------------------------
// music_mode_ctrl
//
// Purpose:
//   Front end for the buzzer tone generator. Turns the note switches, the
//   octave selector and the song/stop pushbuttons into a registered 5-bit
//   mode code:
//     0      silence
//     1-7    low do..si
//     8-14   mid do..si
//     15-16  high do/re
//     17     MerryChristmas
//     18     HappyBirthday
//     19     JiangNan
//   The tone generator restarts on every mode change, so mode only ever
//   changes on a clock edge and goes straight to its target value.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a synchronized button level must hold to be
//                    accepted
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    music_mode_ctrl_if.slave (controls in, mode/playing out)
// ----------------------------------------------------------------------------
module music_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    music_mode_ctrl_if.slave       bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FREE = 2'd1;
    localparam logic [1:0] ST_SONG = 2'd2;

    localparam logic [4:0] MODE_SILENCE = 5'd0;
    localparam logic [4:0] MODE_XMAS    = 5'd17;
    localparam logic [4:0] MODE_BDAY    = 5'd18;
    localparam logic [4:0] MODE_JNAN    = 5'd19;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button vectors are indexed as: bit0 = song, bit1 = stop.
    localparam int BTN_SONG = 0;
    localparam int BTN_STOP = 1;

    logic [6:0]       note_meta;
    logic [6:0]       note_sync;
    logic [1:0]       oct_meta;
    logic [1:0]       oct_sync;
    logic [1:0]       btn_meta;
    logic [1:0]       btn_sync;

    logic [CNT_W-1:0] deb_cnt [2];
    logic [1:0]       deb_level;
    logic [1:0]       deb_level_d;
    logic [1:0]       press;

    logic             note_valid;
    logic [2:0]       note_idx;
    logic [4:0]       note_code;

    logic [1:0]       state_q;
    logic [1:0]       state_next;
    logic [4:0]       mode_q;
    logic [4:0]       mode_next;
    logic             playing_q;

    // ------------------------------------------------------------------------
    // Two-flop synchronizers for every asynchronous input.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_meta <= '0;
            note_sync <= '0;
            oct_meta  <= '0;
            oct_sync  <= '0;
            btn_meta  <= '0;
            btn_sync  <= '0;
        end else begin
            note_meta <= bus.note_sw;
            note_sync <= note_meta;
            oct_meta  <= bus.octave_sel;
            oct_sync  <= oct_meta;
            btn_meta  <= {bus.btn_stop, bus.btn_song};
            btn_sync  <= btn_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Per-button debouncers. The counter only runs while the synchronized
    // level disagrees with the accepted level, so any bounce back to the
    // accepted level restarts the qualification window from zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
            deb_level   <= '0;
            deb_level_d <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_sync[i] == deb_level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_level[i] <= btn_sync[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
            deb_level_d <= deb_level;
        end
    end

    // A press is the single cycle where the accepted level has just risen;
    // holding the button or releasing it produces nothing further.
    assign press = deb_level & ~deb_level_d;

    // ------------------------------------------------------------------------
    // Note decode: the lowest closed switch wins. In the high octave only do
    // and re exist, because codes from 17 upward are taken by the songs.
    // ------------------------------------------------------------------------
    always_comb begin
        note_valid = 1'b0;
        note_idx   = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (note_sync[i]) begin
                note_valid = 1'b1;
                note_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        note_code = MODE_SILENCE;
        if (note_valid) begin
            case (oct_sync)
                2'd0: note_code = {2'b00, note_idx} + 5'd1;
                2'd2: begin
                    if (note_idx == 3'd0) begin
                        note_code = 5'd15;
                    end else if (note_idx == 3'd1) begin
                        note_code = 5'd16;
                    end else begin
                        note_code = MODE_SILENCE;
                    end
                end
                default: note_code = {2'b00, note_idx} + 5'd8;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Mode state machine. Stop always takes precedence over song when both
    // presses land in the same cycle. In SONG the current mode itself
    // records which song is playing, so no separate song index is kept.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_q;
        mode_next  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (press[BTN_SONG] && !press[BTN_STOP]) begin
                    state_next = ST_SONG;
                    mode_next  = MODE_XMAS;
                end else if (note_code != MODE_SILENCE) begin
                    state_next = ST_FREE;
                    mode_next  = note_code;
                end else begin
                    state_next = ST_IDLE;
                    mode_next  = MODE_SILENCE;
                end
            end
            ST_FREE: begin
                if (press[BTN_STOP]) begin
                    state_next = ST_IDLE;
                    mode_next  = MODE_SILENCE;
                end else if (press[BTN_SONG]) begin
                    state_next = ST_SONG;
                    mode_next  = MODE_XMAS;
                end else if (note_code == MODE_SILENCE) begin
                    state_next = ST_IDLE;
                    mode_next  = MODE_SILENCE;
                end else begin
                    state_next = ST_FREE;
                    mode_next  = note_code;
                end
            end
            ST_SONG: begin
                if (press[BTN_STOP]) begin
                    state_next = ST_IDLE;
                    mode_next  = MODE_SILENCE;
                end else if (press[BTN_SONG]) begin
                    state_next = ST_SONG;
                    case (mode_q)
                        MODE_XMAS: mode_next = MODE_BDAY;
                        MODE_BDAY: mode_next = MODE_JNAN;
                        default:   mode_next = MODE_XMAS;
                    endcase
                end
            end
            default: begin
                state_next = ST_IDLE;
                mode_next  = MODE_SILENCE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, mode and playing are registered together so the tone generator
    // only ever sees a settled, self-consistent value.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_SILENCE;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_next;
            mode_q    <= mode_next;
            playing_q <= (state_next == ST_FREE) || (state_next == ST_SONG);
        end
    end

    assign bus.mode    = mode_q;
    assign bus.playing = playing_q;

endmodule
